// File: rtl/edge_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
// The EDGE_CNT_EN macro adds per-channel saturating event counters.
package edge_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_e;

  // The debounce counter has to hold values up to DEB_CYCLES, and it is never narrower than one bit.
  function automatic int dcnt_width(input int deb_cycles);
    return (deb_cycles < 1) ? 1 : $clog2(deb_cycles + 1);
  endfunction

  function automatic logic mode_has_rise(input edge_mode_e m);
    return (m == MODE_RISE) || (m == MODE_BOTH);
  endfunction

  function automatic logic mode_has_fall(input edge_mode_e m);
    return (m == MODE_FALL) || (m == MODE_BOTH);
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: input synchroniser, debounce filter, edge pulses, mode-qualified event.
// When EDGE_CNT_EN is defined, the channel also has a saturating event counter with a clear input.
module edge_chan
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
`ifdef EDGE_CNT_EN
  ,
  parameter int CNT_W       = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic [1:0]       mode,
`ifdef EDGE_CNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt,
`endif
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic             evt
);

  localparam int            DW    = dcnt_width(DEB_CYCLES);
  localparam logic [DW-1:0] DLAST = DW'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [DW-1:0]          dcnt;
  logic                   commit;
  edge_mode_e             m;

  assign s      = sync[SYNC_STAGES-1];
  assign m      = edge_mode_e'(mode);
  assign commit = (s != level) && (dcnt == DLAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync[0] <= a;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
    end
  end

  // Any cycle where s matches the level restarts the stability count, so short glitches die out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      level <= 1'b0;
      dcnt  <= '0;
    end else if (s == level) begin
      dcnt  <= '0;
    end else if (commit) begin
      level <= s;
      dcnt  <= '0;
    end else begin
      dcnt  <= dcnt + 1'b1;
    end
  end

  // mode is sampled only at the commit edge, so a later mode change cannot alter a pulse already issued.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
      evt  <= 1'b0;
    end else begin
      rise <= commit & s;
      fall <= commit & ~s;
      evt  <= (commit & s & mode_has_rise(m)) | (commit & ~s & mode_has_fall(m));
    end
  end

`ifdef EDGE_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // A clear wins over an increment that lands in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (evt && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel debounced edge detector: CH independent edge_chan instances plus an any-event OR.
// When EDGE_CNT_EN is defined, the block adds cnt_clr_i and the packed per-channel counter output cnt_o.
module edge_detect_multi
  import edge_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       a_i,
  input  logic [2*CH-1:0]     mode_i,
`ifdef EDGE_CNT_EN
  input  logic                cnt_clr_i,
  output logic [CH*CNT_W-1:0] cnt_o,
`endif
  output logic [CH-1:0]       level_o,
  output logic [CH-1:0]       rising_edge_o,
  output logic [CH-1:0]       falling_edge_o,
  output logic [CH-1:0]       event_o,
  output logic                any_event_o
);

  if (CH < 1 || CH > 32) begin : g_bad_ch
    $error("edge_detect_multi: CH must be 1..32");
  end
  if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("edge_detect_multi: SYNC_STAGES must be 1..4");
  end
  if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_deb
    $error("edge_detect_multi: DEB_CYCLES must be 1..255");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("edge_detect_multi: CNT_W must be at least 1");
  end

  for (genvar c = 0; c < CH; c++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
`ifdef EDGE_CNT_EN
      ,
      .CNT_W       (CNT_W)
`endif
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .a       (a_i[c]),
      .mode    (mode_i[2*c +: 2]),
`ifdef EDGE_CNT_EN
      .cnt_clr (cnt_clr_i),
      .cnt     (cnt_o[c*CNT_W +: CNT_W]),
`endif
      .level   (level_o[c]),
      .rise    (rising_edge_o[c]),
      .fall    (falling_edge_o[c]),
      .evt     (event_o[c])
    );
  end

  assign any_event_o = |event_o;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Scoreboard bench for edge_detect_multi: a window-based reference model pushes the expected outputs for each
// clock edge, and a monitor compares them against the DUT. The counter checks are active when EDGE_CNT_EN is defined.
module tb_edge_detect_multi;
  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
`ifdef EDGE_CNT_EN
  localparam int CNT_W = 2;
  localparam int CW    = CH * CNT_W;
`else
  localparam int CNT_W = 8;
  localparam int CW    = 0;
`endif
  localparam int EW = 4 * CH + 1 + CW;
  localparam logic [2*CH-1:0] MODE_ALL = '1;
  localparam logic [2*CH-1:0] MODE_MIX = 8'b11_10_00_01;
  localparam logic [2*CH-1:0] MODE_CNT = 8'b11_10_00_11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CH-1:0] a_i = '0;
  logic [2*CH-1:0] mode_i = '0;
  logic [CH-1:0] level_o, rising_edge_o, falling_edge_o, event_o;
  logic          any_event_o;
`ifdef EDGE_CNT_EN
  logic                cnt_clr_i = 1'b0;
  logic [CH*CNT_W-1:0] cnt_o;
`endif

  always #5 clk = ~clk;

  edge_detect_multi #(
    .CH          (CH),
    .SYNC_STAGES (SYNC),
    .DEB_CYCLES  (DEB),
    .CNT_W       (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .a_i            (a_i),
    .mode_i         (mode_i),
`ifdef EDGE_CNT_EN
    .cnt_clr_i      (cnt_clr_i),
    .cnt_o          (cnt_o),
`endif
    .level_o        (level_o),
    .rising_edge_o  (rising_edge_o),
    .falling_edge_o (falling_edge_o),
    .event_o        (event_o),
    .any_event_o    (any_event_o)
  );

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // The reference model keeps the raw input pipeline and the last DEB synchronised samples. A channel
  // commits when every sample in that window differs from its current level.
  logic [CH-1:0] m_level, m_rise, m_fall, m_ev;
  logic [CH-1:0] a_pipe[$];
  logic [CH-1:0] s_hist[$];
  int            m_cnt[CH];

  task automatic model_edge(input logic r, input logic [CH-1:0] a, input logic [2*CH-1:0] md,
                            input logic clr);
    logic [CH-1:0] s;
    logic [CH-1:0] drop;
    logic [EW-1:0] e;
    logic          commit;
    if (!r) begin
      m_level = '0; m_rise = '0; m_fall = '0; m_ev = '0;
      a_pipe.delete(); s_hist.delete();
      for (int i = 0; i < SYNC; i++) a_pipe.push_back('0);
      for (int i = 0; i < DEB; i++) s_hist.push_back('0);
      for (int c = 0; c < CH; c++) m_cnt[c] = 0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (clr) m_cnt[c] = 0;
        else if (m_ev[c] && m_cnt[c] < (1 << CNT_W) - 1) m_cnt[c] = m_cnt[c] + 1;
      end
      s = a_pipe.pop_front();
      a_pipe.push_back(a);
      drop = s_hist.pop_front();
      s_hist.push_back(s);
      for (int c = 0; c < CH; c++) begin
        commit = 1'b1;
        foreach (s_hist[k]) if (s_hist[k][c] == m_level[c]) commit = 1'b0;
        m_rise[c] = commit && s[c];
        m_fall[c] = commit && !s[c];
        m_ev[c]   = commit && (s[c] ? md[2*c] : md[2*c+1]);
        if (commit) m_level[c] = s[c];
      end
    end
    e = '0;
    e[CH-1:0]      = m_level;
    e[2*CH-1:CH]   = m_rise;
    e[3*CH-1:2*CH] = m_fall;
    e[4*CH-1:3*CH] = m_ev;
    e[4*CH]        = |m_ev;
`ifdef EDGE_CNT_EN
    for (int c = 0; c < CH; c++) e[4*CH+1+c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
`endif
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic [CH-1:0] a, input logic [2*CH-1:0] md,
                       input logic clr);
    rst = r;
    a_i = a;
    mode_i = md;
`ifdef EDGE_CNT_EN
    cnt_clr_i = clr;
`endif
    model_edge(r, a, md, clr);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t act=%0h exp=%0h", name, $time, act, exp);
    end
  endtask

  logic [EW-1:0] mon_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("level", 64'(level_o), 64'(mon_e[CH-1:0]));
      check("rise", 64'(rising_edge_o), 64'(mon_e[2*CH-1:CH]));
      check("fall", 64'(falling_edge_o), 64'(mon_e[3*CH-1:2*CH]));
      check("event", 64'(event_o), 64'(mon_e[4*CH-1:3*CH]));
      check("any_event", 64'(any_event_o), 64'(mon_e[4*CH]));
      check("rise_fall_excl", 64'(rising_edge_o & falling_edge_o), 64'(0));
`ifdef EDGE_CNT_EN
      check("cnt", 64'(cnt_o), 64'(mon_e[EW-1:4*CH+1]));
`endif
    end
  end

  initial begin
    logic [CH-1:0] a;
    logic [2*CH-1:0] md;
    int hold;
    // Reset with ch0 already high: one rising pulse after the normal latency
    repeat (2) drive(1'b0, 4'b0001, MODE_ALL, 1'b0);
    repeat (10) drive(1'b1, 4'b0001, MODE_ALL, 1'b0);
    // A 3-cycle glitch on ch1 is rejected, a 4-cycle high commits
    repeat (3) drive(1'b1, 4'b0011, MODE_ALL, 1'b0);
    repeat (8) drive(1'b1, 4'b0001, MODE_ALL, 1'b0);
    repeat (4) drive(1'b1, 4'b0011, MODE_ALL, 1'b0);
    repeat (8) drive(1'b1, 4'b0011, MODE_ALL, 1'b0);
    // ch2 high for 10 cycles, then released
    repeat (10) drive(1'b1, 4'b0111, MODE_ALL, 1'b0);
    repeat (12) drive(1'b1, 4'b0011, MODE_ALL, 1'b0);
    // Mixed modes with edges on every channel
    for (int k = 0; k < 2; k++) begin
      repeat (8) drive(1'b1, 4'b1111, MODE_MIX, 1'b0);
      repeat (8) drive(1'b1, 4'b0000, MODE_MIX, 1'b0);
    end
    // Several ch0 events, so a narrow counter saturates, then a clear lands on an event cycle
    for (int k = 0; k < 3; k++) begin
      repeat (7) drive(1'b1, 4'b0001, MODE_CNT, 1'b0);
      repeat (7) drive(1'b1, 4'b0000, MODE_CNT, 1'b0);
    end
    repeat (7) drive(1'b1, 4'b0001, MODE_CNT, m_ev[0]);
    repeat (7) drive(1'b1, 4'b0000, MODE_CNT, m_ev[0]);
    repeat (4) drive(1'b1, 4'b0000, MODE_CNT, 1'b0);
    // Reset while ch0 is mid-debounce, then stay low
    repeat (4) drive(1'b1, 4'b0001, MODE_ALL, 1'b0);
    drive(1'b0, 4'b0000, MODE_ALL, 1'b0);
    repeat (12) drive(1'b1, 4'b0000, MODE_ALL, 1'b0);
    // Randomised traffic
    a = '0;
    md = MODE_ALL;
    for (int k = 0; k < 150; k++) begin
      for (int c = 0; c < CH; c++) if ($urandom_range(0, 2) == 0) a[c] = ~a[c];
      if ($urandom_range(0, 7) == 0) md = $urandom_range(0, 255);
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        drive(($urandom_range(0, 80) != 0), a, md, ($urandom_range(0, 15) == 0));
      end
    end
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
- Parametrised, multi-channel successor to the single-bit rising/falling edge detector.
- Each channel has:
  - a configurable input synchroniser;
  - a debounce filter that rejects glitches shorter than DEB_CYCLES;
  - registered one-cycle rising and falling pulses;
  - a per-channel mode mask that produces a qualified event output.
- Sits between asynchronous inputs (buttons, external strobes) and control logic or interrupt aggregation.

Parameters:
- CH, 4, number of independent channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per channel (1..4).
- DEB_CYCLES, 4, consecutive stable cycles required before the filtered level changes (1..255). A value of 1 means no filtering.
- CNT_W, 8, event-counter width. Used only when EDGE_CNT_EN is defined.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-low reset. 0 = reset asserted, sampled on rising clk.
- a_i  input  CH  raw asynchronous inputs, one bit per channel.
- mode_i  input  2*CH  per-channel mode, bits [2c+1:2c]: 00 off, 01 rising, 10 falling, 11 both.
- level_o  output  CH  debounced level per channel.
- rising_edge_o  output  CH  one-cycle pulse on a filtered 0->1 transition.
- falling_edge_o  output  CH  one-cycle pulse on a filtered 1->0 transition.
- event_o  output  CH  edge pulses qualified by mode_i.
- any_event_o  output  1  OR of all event_o bits.

Behaviour:
- Reset (rst==0 at a rising clk): all synchroniser flops, level_o, debounce counters, rising_edge_o, falling_edge_o, event_o and counters are cleared to 0. any_event_o therefore reads 0.
- Synchroniser: chain of SYNC_STAGES flops. s = last stage.
- Debounce, per channel, counter dcnt of width clog2(DEB_CYCLES+1):
  - s == level: dcnt <= 0.
  - s != level and dcnt < DEB_CYCLES-1: dcnt <= dcnt+1.
  - s != level and dcnt == DEB_CYCLES-1: level <= s and dcnt <= 0. This is the "commit" edge.
- Glitch rejection: a mismatch lasting fewer than DEB_CYCLES consecutive cycles produces no level change and no pulse. dcnt restarts from 0 on any return to match.
- Edge pulses (registered, same edge as commit):
  - rising_edge_o[c] <= commit & s.
  - falling_edge_o[c] <= commit & ~s.
  - Each pulse lasts exactly one cycle. Rising and falling can never both be high on the same channel.
- Latency: if a new a_i value is first sampled at edge 1, level_o and the pulse update on edge SYNC_STAGES+DEB_CYCLES. With default parameters that is edge 6.
- Events:
  - event_o[c] <= (commit & s & mode[0]) | (commit & ~s & mode[1]), registered alongside the pulses.
  - any_event_o is the combinational OR of the registered event_o bits.
- mode_i is sampled at the commit edge. A mode change therefore never truncates or creates a pulse retroactively. mode 00 suppresses event_o only; level_o and the raw pulses are unaffected.
- Channels are fully independent. Simultaneous edges on several channels each pulse in the same cycle.
- Reset asserted mid-debounce discards the pending count; no pulse is produced.
- If a_i is 1 at reset release, a rising edge is reported after the normal latency, because level starts at 0.

Optional Feature:
- Macro EDGE_CNT_EN.
- When defined, two ports are added:
  - cnt_clr_i  input  1;
  - cnt_o  output  CH*CNT_W, channel c occupying bits [c*CNT_W +: CNT_W].
- Each channel counter increments on event_o and saturates at 2^CNT_W-1; it does not wrap.
- cnt_clr_i == 1 clears all counters to 0 and takes priority over a simultaneous increment.
- Counters reset to 0.
- When the macro is not defined, the ports and counter logic are absent. All other behaviour is identical.

Decomposition:
- Package edge_pkg holds:
  - the edge_mode_e enum (MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11);
  - the localparam/function used to compute dcnt width.
- Sub-module edge_chan implements one channel: synchroniser, debounce counter, pulse, event and optional counter. It is instantiated CH times in a generate loop.
- The top level adds only the any_event_o OR and, under EDGE_CNT_EN, the cnt_clr_i fan-out.

Test Plan:
1. Reset with a_i=4'b0001 held, defaults, rst released before edge 1:
   - rising_edge_o[0] is high for exactly one cycle after edge 6 and level_o[0]=1 at the same time;
   - channels 1..3 stay 0.
2. Glitch: a_i[1] high for 3 cycles (DEB_CYCLES=4):
   - level_o[1] stays 0, no rising_edge_o[1] or falling_edge_o[1] pulse;
   - a_i[1] then held high for 4 cycles gives one rising pulse.
3. Pulse then release on a_i[2]: high for 10 cycles, then low:
   - one rising pulse, then one falling pulse exactly 10 cycles later;
   - never both high together.
4. Modes mode_i=8'b11_10_00_01 with edges on all channels:
   - ch0 event_o on rising only; ch1 event_o never (raw pulses still present);
   - ch2 event_o on falling only; ch3 event_o on both;
   - any_event_o matches the OR of event_o.
5. With EDGE_CNT_EN defined, CNT_W=2, 5 events on ch0:
   - cnt_o[1:0]=3 (saturated);
   - cnt_clr_i asserted in the same cycle as an event gives 0 on the next cycle.
6. Reset mid-operation: rst=0 while ch0 dcnt=2:
   - all outputs are 0 the next cycle;
   - after release with a_i[0] low, no pulse ever appears.
